// File: rtl/alu_pipe.sv
// Handshaked execute ALU: single-cycle ops land in a registered output stage,
// MUL runs as a WIDTH-cycle shift-add loop that holds off new input while busy.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_op,
    input  logic             c_in,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       status_bits,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand_p0;
    logic [WIDTH-1:0]   mplier_p0;
    logic [WIDTH-1:0]   acc_p0;
    logic [CNT_W-1:0]   cnt_p0;
    logic [TAG_W-1:0]   tag_p0;

    logic [WIDTH+1:0]   ex_out;
    logic [WIDTH-1:0]   ex_res;
    logic               ex_c;
    logic               ex_v;
    logic               mul_bit;
    logic [WIDTH-1:0]   acc_next;

    // Returns {C, V, result} for every non-MUL opcode.
    function automatic logic [WIDTH+1:0] exec(input logic [3:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic cin);
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        ext = '0;
        res = WIDTH'(10);
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_MOV: res = b;
            OP_MVN: res = ~b;
            OP_AND: res = a & b;
            OP_ORR: res = a | b;
            OP_EOR: res = a ^ b;
            OP_ADD, OP_ADC: begin
                ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
                res = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                // SBC borrows when the incoming carry is clear.
                ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBC) & ~cin};
                res = ext[WIDTH-1:0];
                c   = ~ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            default: res = WIDTH'(10);
        endcase
        return {c, v, res};
    endfunction

    function automatic logic [3:0] flags(input logic [WIDTH-1:0] res,
                                         input logic c,
                                         input logic v);
        return {res == '0, c, v, res[WIDTH-1]};
    endfunction

    assign ex_out   = exec(alu_op, src_a, src_b, c_in);
    assign ex_res   = ex_out[WIDTH-1:0];
    assign ex_v     = ex_out[WIDTH];
    assign ex_c     = ex_out[WIDTH+1];

    assign mul_bit  = |(mplier_p0 & (WIDTH'(1) << cnt_p0));
    assign acc_next = mul_bit ? acc_p0 + (mcand_p0 << cnt_p0) : acc_p0;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);

    // Output stage: loaded by single-cycle ops on accept, or by MUL on its final iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            alu_result  <= '0;
            status_bits <= '0;
            out_tag     <= '0;
            cnt_p0      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        if (alu_op == OP_MUL) begin
                            mcand_p0  <= src_a;
                            mplier_p0 <= src_b;
                            tag_p0    <= in_tag;
                            acc_p0    <= '0;
                            cnt_p0    <= '0;
                            state     <= BUSY;
                        end else begin
                            alu_result  <= ex_res;
                            status_bits <= flags(ex_res, ex_c, ex_v);
                            out_tag     <= in_tag;
                            out_valid   <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    acc_p0 <= acc_next;
                    cnt_p0 <= cnt_p0 + 1'b1;
                    if (cnt_p0 == CNT_LAST) begin
                        alu_result  <= acc_next;
                        status_bits <= flags(acc_next, 1'b0, 1'b0);
                        out_tag     <= tag_p0;
                        out_valid   <= 1'b1;
                        cnt_p0      <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=8: directed cases plus randomized traffic checked
// against an integer-arithmetic model of the op set and the handshake.
module tb_alu_pipe;

    localparam int     W  = 8;
    localparam int     TW = 5;
    localparam longint M  = 256;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [3:0]    alu_op;
    logic          c_in;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  alu_result;
    logic [3:0]    status_bits;
    logic [TW-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .src_a(src_a), .src_b(src_b), .alu_op(alu_op), .c_in(c_in), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .status_bits(status_bits), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [TW-1:0] tag);
        alu_op = op; src_a = a; src_b = b; c_in = cin; in_tag = tag;
    endtask

    // Reference: {result, Z, C, V, N} from plain integer arithmetic.
    function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
        longint ua, ub, sa, sb, r, s, bw;
        bit c, v;
        logic [W-1:0] res;
        ua = longint'(a); ub = longint'(b);
        sa = (ua >= M/2) ? ua - M : ua;
        sb = (ub >= M/2) ? ub - M : ub;
        c = 0; v = 0;
        case (op)
            4'd1:  r = ub;
            4'd9:  r = M - 1 - ub;
            4'd2, 4'd3: begin
                bw = (op == 4'd3 && cin) ? 1 : 0;
                r = ua + ub + bw;  s = sa + sb + bw;
                c = (r >= M);  v = (s >= M/2) || (s < -M/2);
            end
            4'd4, 4'd5: begin
                bw = (op == 4'd5 && !cin) ? 1 : 0;
                r = ua - ub - bw;  s = sa - sb - bw;
                c = (r >= 0);  v = (s >= M/2) || (s < -M/2);
            end
            4'd6:  r = ua & ub;
            4'd7:  r = ua | ub;
            4'd8:  r = ua ^ ub;
            4'd10: r = ua * ub;
            default: r = 10;
        endcase
        r   = r & (M - 1);
        res = r[W-1:0];
        return {res, res == 0, c, v, res[W-1]};
    endfunction

    task automatic single(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin, input logic [TW-1:0] tag,
                          input logic [W-1:0] exp_res, input logic [3:0] exp_st);
        drive(op, a, b, cin, tag);
        in_valid = 1; out_ready = 1;
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'(1));
        tick();
        in_valid = 0;
        chk({name, "_valid"}, 32'(out_valid), 32'(1));
        chk({name, "_result"}, 32'(alu_result), 32'(exp_res));
        chk({name, "_status"}, 32'(status_bits), 32'(exp_st));
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
    endtask

    logic [W+3:0]    e;
    logic [W+3+TW:0] pend;
    int              busy;
    bit              mov;
    bit              exp_rdy;

    initial begin
        rst = 1; in_valid = 0; out_ready = 1;
        drive(4'd0, '0, '0, 0, '0);
        tick(); tick();
        chk("reset_valid", 32'(out_valid), 32'(0));
        chk("reset_result", 32'(alu_result), 32'(0));
        chk("reset_status", 32'(status_bits), 32'(0));
        chk("reset_tag", 32'(out_tag), 32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        rst = 0;
        tick();

        single("add_wrap", 4'd2, 8'hFF, 8'h01, 0, 5'd1, 8'h00, 4'b1100);
        single("sub_ovf", 4'd4, 8'h80, 8'h01, 0, 5'd2, 8'h7F, 4'b0110);
        single("sbc", 4'd5, 8'd5, 8'd3, 0, 5'd3, 8'd1, 4'b0100);
        single("adc_ovf", 4'd3, 8'h7F, 8'h00, 1, 5'd4, 8'h80, 4'b0011);
        single("undef_op", 4'd15, 8'hAA, 8'h55, 1, 5'd5, 8'd10, 4'b0000);

        // MUL 0x0F*0x11 = 0xFF, done WIDTH cycles after accept
        drive(4'd10, 8'h0F, 8'h11, 0, 5'd3);
        in_valid = 1; out_ready = 1;
        #1;
        chk("mul_accept_ready", 32'(in_ready), 32'(1));
        tick();
        in_valid = 0;
        for (int i = 1; i <= W; i++) begin
            drive(4'd2, 8'($urandom), 8'($urandom), 0, 5'd9);
            #1;
            chk("mul_busy_ready", 32'(in_ready), 32'(0));
            chk("mul_busy_valid", 32'(out_valid), 32'(0));
            tick();
        end
        chk("mul_valid", 32'(out_valid), 32'(1));
        chk("mul_result", 32'(alu_result), 32'(8'hFF));
        chk("mul_status", 32'(status_bits), 32'(4'b0001));
        chk("mul_tag", 32'(out_tag), 32'(3));
        chk("mul_done_ready", 32'(in_ready), 32'(1));
        tick();
        chk("mul_drained", 32'(out_valid), 32'(0));

        // Back-to-back ORR/EOR/MVN with a 3-cycle output stall after the first
        out_ready = 0;
        drive(4'd7, 8'h5A, 8'h0F, 0, 5'd7);
        in_valid = 1;
        #1;
        chk("stall_first_ready", 32'(in_ready), 32'(1));
        tick();
        e = model(4'd7, 8'h5A, 8'h0F, 0);
        drive(4'd8, 8'h3C, 8'hFF, 0, 5'd8);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 32'(in_ready), 32'(0));
            chk("stall_valid", 32'(out_valid), 32'(1));
            chk("stall_result", 32'(alu_result), 32'(e[W+3:4]));
            chk("stall_tag", 32'(out_tag), 32'(7));
            tick();
        end
        out_ready = 1;
        #1;
        chk("stall_release_ready", 32'(in_ready), 32'(1));
        chk("stall_release_result", 32'(alu_result), 32'(e[W+3:4]));
        tick();
        e = model(4'd8, 8'h3C, 8'hFF, 0);
        chk("eor_result", 32'(alu_result), 32'(e[W+3:4]));
        chk("eor_status", 32'(status_bits), 32'(e[3:0]));
        chk("eor_tag", 32'(out_tag), 32'(8));
        drive(4'd9, 8'h00, 8'h0F, 0, 5'd9);
        tick();
        in_valid = 0;
        e = model(4'd9, 8'h00, 8'h0F, 0);
        chk("mvn_result", 32'(alu_result), 32'(e[W+3:4]));
        chk("mvn_status", 32'(status_bits), 32'(e[3:0]));
        chk("mvn_tag", 32'(out_tag), 32'(9));
        tick();
        chk("b2b_drained", 32'(out_valid), 32'(0));

        // Randomized traffic against the model; at most one result is ever pending
        busy = 0; mov = 0; pend = '0;
        for (int n = 0; n < 400; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            drive(($urandom_range(0, 5) == 0) ? 4'd10 : 4'($urandom_range(0, 15)),
                  8'($urandom), 8'($urandom), 1'($urandom), 5'($urandom));
            #1;
            exp_rdy = (busy == 0) && (!mov || out_ready);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rnd_out_valid", 32'(out_valid), 32'(mov));
            if (mov) begin
                chk("rnd_result", 32'(alu_result), 32'(pend[W+3+TW:4+TW]));
                chk("rnd_status", 32'(status_bits), 32'(pend[3+TW:TW]));
                chk("rnd_tag", 32'(out_tag), 32'(pend[TW-1:0]));
            end
            if (mov && out_ready) mov = 0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) mov = 1;
            end
            if (in_valid && exp_rdy) begin
                pend = {model(alu_op, src_a, src_b, c_in), in_tag};
                if (alu_op == 4'd10) busy = W;
                else mov = 1;
            end
            tick();
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i <= W; i++) tick();

        // Reset pulse while a result is held on a stalled output
        out_ready = 0;
        drive(4'd2, 8'h12, 8'h34, 0, 5'd6);
        in_valid = 1;
        tick();
        in_valid = 0;
        chk("pre_rst_valid", 32'(out_valid), 32'(1));
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid_valid", 32'(out_valid), 32'(0));
        chk("rst_mid_result", 32'(alu_result), 32'(0));
        chk("rst_mid_status", 32'(status_bits), 32'(0));
        chk("rst_mid_in_ready", 32'(in_ready), 32'(1));

        // Reset during the fourth MUL iteration must discard the product
        out_ready = 1;
        drive(4'd10, 8'hFF, 8'hFF, 0, 5'd4);
        in_valid = 1;
        tick();
        in_valid = 0;
        tick(); tick(); tick();
        chk("mul_rst_busy", 32'(in_ready), 32'(0));
        rst = 1;
        tick();
        rst = 0;
        chk("mul_rst_in_ready", 32'(in_ready), 32'(1));
        chk("mul_rst_valid", 32'(out_valid), 32'(0));
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mul_rst_no_stale", 32'(out_valid), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
